// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types, glyphs and range bounds for the calculator display
package calc_pkg;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        SHOW  = 2'd1,
        ERROR = 2'd2
    } state_e;

    // Segment order is {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_MINUS = 7'b0000001;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_R     = 7'b0000101;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [4:0] POS_MAX = 5'd18;
    localparam logic [4:0] NEG_MIN = 5'd23;

    localparam int unsigned CNT_W = 20;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1111110;
            4'd1:    g = 7'b0110000;
            4'd2:    g = 7'b1101101;
            4'd3:    g = 7'b1111001;
            4'd4:    g = 7'b0110011;
            4'd5:    g = 7'b1011011;
            4'd6:    g = 7'b1011111;
            4'd7:    g = 7'b1110000;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1111011;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Codes 19..22 cannot come out of a single-digit add or subtract.
    function automatic logic is_unreachable(input logic [4:0] r);
        return (r > POS_MAX) && (r < NEG_MIN);
    endfunction

endpackage

// File: rtl/calc_bin2sd_v.sv
// rtl/calc_bin2sd_v.sv - 5-bit calculator result to tens/sign and ones glyphs
module calc_bin2sd_v
    import calc_pkg::*;
(
    input  logic [4:0] result_i,
    output logic [6:0] tens_glyph_o,
    output logic [6:0] ones_glyph_o,
    output logic       err_o
);

    logic [3:0] ones_digit;
    logic [6:0] ones_seg;

    always_comb begin
        ones_digit   = 4'd0;
        tens_glyph_o = SEG_BLANK;
        err_o        = 1'b0;
        if (result_i <= POS_MAX) begin
            if (result_i >= 5'd10) begin
                tens_glyph_o = digit_glyph(4'd1);
                ones_digit   = 4'(result_i - 5'd10);
            end else begin
                tens_glyph_o = digit_glyph(4'd0);
                ones_digit   = result_i[3:0];
            end
        end else if (result_i >= NEG_MIN) begin
            // Two's-complement magnitude of the low nibble: 10111 -> 9 ... 11111 -> 1.
            tens_glyph_o = SEG_MINUS;
            ones_digit   = (~result_i[3:0]) + 4'd1;
        end else begin
            tens_glyph_o = SEG_E;
            err_o        = 1'b1;
        end
    end

    seg_decoder_v u_ones_dec (
        .digit_i (ones_digit),
        .seg_o   (ones_seg)
    );

    assign ones_glyph_o = err_o ? SEG_R : ones_seg;

endmodule

// File: rtl/seg_decoder_v.sv
// rtl/seg_decoder_v.sv - BCD digit to active-high abcdefg segment pattern
module seg_decoder_v
    import calc_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = digit_glyph(digit_i);
    end

endmodule

// File: rtl/calc_display_v.sv
// rtl/calc_display_v.sv - result capture, classification FSM and two-digit 7-segment scan
module calc_display_v
    import calc_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOAD,
    input  logic [4:0] RESULT,
    output logic [6:0] SEG,
    output logic [1:0] AN,
    output logic       ERR
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    state_e           state_q, state_d;
    logic [4:0]       value_q, value_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             digit_q, digit_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             err_q, err_d;

    logic [6:0]       tens_glyph;
    logic [6:0]       ones_glyph;
    logic             disp_err;

    calc_bin2sd_v u_bin2sd (
        .result_i     (value_q),
        .tens_glyph_o (tens_glyph),
        .ones_glyph_o (ones_glyph),
        .err_o        (disp_err)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= BLANK;
            value_q <= 5'd0;
            cnt_q   <= '0;
            digit_q <= 1'b0;
            seg_q   <= SEG_BLANK;
            an_q    <= 2'b11;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        if (LOAD) begin
            value_d = RESULT;
            state_d = is_unreachable(RESULT) ? ERROR : SHOW;
        end
    end

    // Scan timing is independent of LOAD so the digit phase never slips.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        digit_d = digit_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            digit_d = ~digit_q;
        end
    end

    // AN and SEG are selected from the same digit_q so enable and glyph always match.
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = 2'b11;
        err_d = 1'b0;
        if (state_q != BLANK) begin
            err_d = disp_err;
            if (digit_q) begin
                an_d  = 2'b01;
                seg_d = tens_glyph;
            end else begin
                an_d  = 2'b10;
                seg_d = ones_glyph;
            end
        end
    end

    assign SEG = seg_q;
    assign AN  = an_q;
    assign ERR = err_q;

endmodule

// File: tb/tb_calc_display_v.sv
// tb/tb_calc_display_v.sv - directed self-checking bench for calc_display_v
module tb_calc_display_v;

    logic       CLK;
    logic       RST;
    logic       LOAD;
    logic [4:0] RESULT;
    logic [6:0] SEG;
    logic [1:0] AN;
    logic       ERR;

    int errs   = 0;
    int checks = 0;

    calc_display_v #(.SCAN_DIV(4)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .LOAD   (LOAD),
        .RESULT (RESULT),
        .SEG    (SEG),
        .AN     (AN),
        .ERR    (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    // Returns at the negedge after the edge that sampled LOAD=1.
    task automatic do_load(input logic [4:0] r);
        @(negedge CLK);
        LOAD   = 1'b1;
        RESULT = r;
        @(negedge CLK);
        LOAD   = 1'b0;
    endtask

    task automatic wait_an(input logic [1:0] want, input string tag);
        int n;
        n = 0;
        while (AN !== want && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_an"}, 16'(AN), 16'(want));
    endtask

    task automatic show_check(input string tag, input logic [6:0] tens, input logic [6:0] ones,
                              input logic err);
        wait_an(2'b10, {tag, "_ones"});
        check({tag, "_ones_seg"}, 16'(SEG), 16'(ones));
        check({tag, "_ones_err"}, 16'(ERR), 16'(err));
        wait_an(2'b01, {tag, "_tens"});
        check({tag, "_tens_seg"}, 16'(SEG), 16'(tens));
        check({tag, "_tens_err"}, 16'(ERR), 16'(err));
    endtask

    task automatic measure_period(input string tag, input bit load_mid);
        logic [1:0] prev;
        int n;
        prev = AN;
        n = 0;
        while (AN === prev && n < 20) begin
            @(negedge CLK);
            n++;
        end
        prev = AN;
        n = 0;
        while (AN === prev && n < 20) begin
            @(negedge CLK);
            n++;
            if (load_mid && n == 2) begin
                LOAD   = 1'b1;
                RESULT = 5'b00101;
            end else begin
                LOAD = 1'b0;
            end
        end
        LOAD = 1'b0;
        check(tag, 16'(n), 16'd4);
    endtask

    initial begin
        RST    = 1'b1;
        LOAD   = 1'b0;
        RESULT = 5'd0;
        tick(2);
        RST = 1'b0;

        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("blank_idle", {6'd0, ERR, AN, SEG}, {6'd0, 1'b0, 2'b11, 7'b0000000});
        end

        do_load(5'b10010);
        check("latency_old_an", 16'(AN), 16'(2'b11));
        tick(1);
        check("latency_new_lit", 16'(AN == 2'b11), 16'd0);
        show_check("p18", 7'b0110000, 7'b1111111, 1'b0);

        do_load(5'b11110);
        tick(1);
        show_check("n2", 7'b0000001, 7'b1101101, 1'b0);

        do_load(5'b10111);
        tick(1);
        show_check("n9", 7'b0000001, 7'b1111011, 1'b0);

        do_load(5'b10100);
        check("err_latency_old", 16'(ERR), 16'd0);
        tick(1);
        check("err_latency_new", 16'(ERR), 16'd1);
        show_check("err", 7'b1001111, 7'b0000101, 1'b1);

        do_load(5'b00000);
        tick(1);
        show_check("p0", 7'b1111110, 7'b1111110, 1'b0);

        // Back-to-back loads: the second one must win.
        @(negedge CLK);
        LOAD   = 1'b1;
        RESULT = 5'b10011;
        @(negedge CLK);
        RESULT = 5'b01100;
        @(negedge CLK);
        LOAD = 1'b0;
        tick(1);
        show_check("b2b", 7'b0110000, 7'b1101101, 1'b0);

        measure_period("period_a", 1'b0);
        measure_period("period_load", 1'b1);
        measure_period("period_b", 1'b0);
        show_check("p5", 7'b1111110, 7'b1011011, 1'b0);

        @(negedge CLK);
        RST    = 1'b1;
        LOAD   = 1'b1;
        RESULT = 5'b00111;
        @(negedge CLK);
        RST  = 1'b0;
        LOAD = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("rst_load_blank", {6'd0, ERR, AN, SEG}, {6'd0, 1'b0, 2'b11, 7'b0000000});
        end

        do_load(5'b00111);
        tick(1);
        show_check("p7", 7'b1111110, 7'b1110000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
